wbm_seq: RTL

- Wishbone classic initiator: the requester side of the wb_* slave register/SRAM interface used in the user project.
- Accepts one command (read or write, base address, beat count, data seed) and issues single classic cycles, one word per beat.
- Write beats carry a generated pattern. Read beats are checked against the same pattern.
- Used on-chip and in benches to exercise and self-test the wishbone slave blocks; status is exported toward the LA.

---
 rtl/wbm_seq_pkg.sv | 21 ++
 rtl/wbm_seq_chk.sv | 43 ++++
 rtl/wbm_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/wbm_seq_pkg.sv
// Shared constants and helpers for the wishbone classic test-sequence initiator.
// State codes are plain constants so the FSM encoding is fixed across tools.
package wbm_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_GAP  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam logic [31:0] ADDR_STEP   = 32'd4;
    localparam logic [3:0]  SEL_ALL     = 4'hF;
    localparam int          TIMEOUT_DEF = 64;

    // Beat address wraps naturally at 32 bits.
    function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + idx * ADDR_STEP;
    endfunction

endpackage

// File: rtl/wbm_seq_chk.sv
// Pattern generator and read-data checker with a saturating mismatch counter.
// The counter clears when a new command is accepted.
module wbm_seq_chk #(
    parameter int LEN_W = 8,
    parameter int ERR_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             ack_en_i,
    input  logic [31:0]      seed_i,
    input  logic [LEN_W-1:0] idx_i,
    input  logic [31:0]      rdata_i,
    output logic [31:0]      pattern_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    logic [ERR_W-1:0] err_q, err_d;
    logic             mismatch;

    assign pattern_o = seed_i + 32'(idx_i);
    assign mismatch  = (rdata_i != pattern_o);

    always_comb begin
        err_d = err_q;
        if (clr_i) begin
            err_d = '0;
        end else if (ack_en_i && mismatch && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt_o = err_q;

endmodule

// File: rtl/wbm_seq.sv
// Wishbone classic initiator: issues one single-beat cycle per word of a command.
// Optional per-beat ack timeout is compiled in with WBM_TIMEOUT_EN.
module wbm_seq
    import wbm_seq_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int ERR_W   = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [31:0]      cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic [31:0]      cmd_seed_i,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [31:0]      last_rdata_o,
    output logic             timeout_o
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q;
    logic [31:0]      base_q;
    logic [31:0]      seed_q;
    logic             we_q;
    logic [31:0]      last_rdata_q;
    logic [31:0]      pattern;

    logic in_req;
    logic accept;
    logic beat_ack;
    logic last_beat;
    logic to_hit;

    assign in_req    = (state_q == ST_REQ);
    assign accept    = cmd_valid_i && (state_q == ST_IDLE);
    assign beat_ack  = in_req && wbm_ack_i;
    assign last_beat = (idx_q == (len_q - LEN_W'(1)));

`ifdef WBM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_flag_q, to_flag_d;

    // Counter is zero on every entry into REQ since it only advances while waiting.
    assign to_hit = in_req && !wbm_ack_i && (to_cnt_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        to_cnt_d  = (in_req && !wbm_ack_i) ? (to_cnt_q + TO_W'(1)) : '0;
        to_flag_d = to_flag_q;
        if (accept) begin
            to_flag_d = 1'b0;
        end else if (to_hit) begin
            to_flag_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
        end
    end

    assign timeout_o = to_flag_q;
`else
    assign to_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    idx_d   = '0;
                    state_d = (cmd_len_i == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (wbm_ack_i) begin
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + LEN_W'(1);
                        state_d = ST_GAP;
                    end
                end else if (to_hit) begin
                    state_d = ST_DONE;
                end
            end
            // The slave only acks once its own ready has dropped, so strobe must go low between beats.
            ST_GAP:  state_d = ST_REQ;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            base_q       <= '0;
            seed_q       <= '0;
            we_q         <= 1'b0;
            last_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                len_q  <= cmd_len_i;
                base_q <= {cmd_addr_i[31:2], 2'b00};
                seed_q <= cmd_seed_i;
                we_q   <= cmd_we_i;
            end
            if (beat_ack && !we_q) begin
                last_rdata_q <= wbm_dat_i;
            end
        end
    end

    wbm_seq_chk #(
        .LEN_W(LEN_W),
        .ERR_W(ERR_W)
    ) u_chk (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .clr_i     (accept),
        .ack_en_i  (beat_ack && !we_q),
        .seed_i    (seed_q),
        .idx_i     (idx_q),
        .rdata_i   (wbm_dat_i),
        .pattern_o (pattern),
        .err_cnt_o (err_cnt_o)
    );

    // Bus outputs decode straight from state so an async reset drops them immediately.
    assign wbm_cyc_o    = in_req;
    assign wbm_stb_o    = in_req;
    assign wbm_we_o     = in_req && we_q;
    assign wbm_sel_o    = in_req ? SEL_ALL : 4'h0;
    assign wbm_adr_o    = in_req ? beat_addr(base_q, 32'(idx_q)) : 32'h0;
    assign wbm_dat_o    = (in_req && we_q) ? pattern : 32'h0;

    assign cmd_ready_o  = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign last_rdata_o = last_rdata_q;

endmodule
